// File: rtl/simple_bus_pkg.sv
// Shared types and default sizing for the simple bus master slice.
package simple_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } master_state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/simple_bus_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, explicit occupancy count.
module simple_bus_cmd_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (PW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/simple_bus_master.sv
// Single-outstanding bus master: queued commands, registered bus requests with
// timeout abort, and a held response until consumed.
module simple_bus_master
  import simple_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wr_en,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         raddr,
  output logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          rd_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CW    = $clog2(TIMEOUT + 1);

  master_state_e         state_q, state_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                  iss_write_q, iss_write_d;
  logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_WIDTH-1:0] iss_wdata_q, iss_wdata_d;
  logic                  rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic             fifo_full, fifo_empty, fifo_pop, push;
  logic [CMD_W-1:0] head;
  logic             bus_ready;

  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  simple_bus_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({cmd_write, cmd_addr, cmd_wdata}),
    .pop      (fifo_pop),
    .pop_data (head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus_ready = iss_write_q ? wr_ready : rd_ready;
  assign cnt_inc   = cnt_q + CW'(1);

  // The first REQ cycle only launches the enable; ready and the timeout
  // count are considered only while an enable is actually high.
  always_comb begin
    state_d     = state_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    cnt_d       = cnt_q;
    iss_write_d = iss_write_q;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          iss_write_d = head[CMD_W-1];
          iss_addr_d  = head[DATA_WIDTH +: ADDR_WIDTH];
          iss_wdata_d = head[DATA_WIDTH-1:0];
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!(wr_en_q || rd_en_q)) begin
          wr_en_d = iss_write_q;
          rd_en_d = !iss_write_q;
        end else begin
          cnt_d = cnt_inc;
          if (bus_ready || cnt_inc == CW'(TIMEOUT)) begin
            wr_en_d     = 1'b0;
            rd_en_d     = 1'b0;
            cnt_d       = '0;
            state_d     = ST_RESP;
            rsp_write_d = iss_write_q;
            rsp_err_d   = !bus_ready;
            rsp_rdata_d = (bus_ready && !iss_write_q) ? rdata : '0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      cnt_q       <= '0;
      iss_write_q <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      cnt_q       <= cnt_d;
      iss_write_q <= iss_write_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign waddr     = iss_addr_q;
  assign wdata     = iss_wdata_q;
  assign raddr     = iss_addr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule
